i12287_bench_core: RTL and testbench

- Small clocked benchmark core for a five-input, one-output sequential circuit, used in the gate-level trojan-detection benchmark set.
- Computes a fixed Boolean function of the 5-bit input word and registers the result.
- A run-length monitor counts consecutive all-ones words; once it reaches a threshold, a sticky flag inverts the registered output until reset.
- Sits as a leaf under its own test wrapper; no bus interfaces.

---
 rtl/i12287_pkg.sv | 16 +
 rtl/i12287_run_monitor.sv | 45 ++++
 rtl/i12287_bench_core.sv | 49 ++++
 tb/tb_i12287_bench_core.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/i12287_pkg.sv
// Shared types and constants for the i12287 benchmark core.
package i12287_pkg;

  // Input word {N0,N1,N2,N3,N4}, N0 is the MSB.
  typedef logic [4:0] word_t;

  localparam word_t       ALL_ONES       = 5'b11111;
  localparam int unsigned DEF_TRIG_COUNT = 4;
  localparam int unsigned DEF_CNT_W      = 4;

  // Core Boolean function: (N0 & N1) ^ (N2 | N3) ^ N4.
  function automatic logic core_func(input word_t w);
    return (w[4] & w[3]) ^ (w[2] | w[1]) ^ w[0];
  endfunction

endpackage

// File: rtl/i12287_run_monitor.sv
// Counts consecutive all-ones words and sets a sticky flag at the threshold.
module i12287_run_monitor
  import i12287_pkg::*;
#(
  parameter int unsigned TRIG_COUNT = DEF_TRIG_COUNT,
  parameter int unsigned CNT_W      = DEF_CNT_W
) (
  input  logic  clk,
  input  logic  reset,
  input  word_t word,
  output logic  armed_next
);

  localparam logic [CNT_W-1:0] TrigCnt  = CNT_W'(TRIG_COUNT);
  localparam logic [CNT_W-1:0] TrigLast = CNT_W'(TRIG_COUNT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             armed_q;
  logic             all_ones;

  // Next run length (saturating) and the flag value taken on this edge.
  always_comb begin
    all_ones   = (word == ALL_ONES);
    cnt_d      = '0;
    armed_next = armed_q;
    if (all_ones) begin
      cnt_d = (cnt_q < TrigCnt) ? cnt_q + CNT_W'(1) : cnt_q;
      if (cnt_q == TrigLast) begin
        armed_next = 1'b1;
      end
    end
  end

  // Run counter and sticky flag; reset wins over an all-ones word.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      armed_q <= armed_next;
    end
  end

endmodule

// File: rtl/i12287_bench_core.sv
// Registered Boolean function of a 5-bit word, inverted once the run monitor arms.
module i12287_bench_core
  import i12287_pkg::*;
#(
  parameter int unsigned TRIG_COUNT = DEF_TRIG_COUNT,
  parameter int unsigned CNT_W      = DEF_CNT_W
) (
  input  logic CK,
  input  logic reset,
  input  logic N0,
  input  logic N1,
  input  logic N2,
  input  logic N3,
  input  logic N4,
  output logic Z
);

  word_t word;
  logic  armed_next;
  logic  z_d, z_q;

  i12287_run_monitor #(
    .TRIG_COUNT(TRIG_COUNT),
    .CNT_W     (CNT_W)
  ) u_run_monitor (
    .clk       (CK),
    .reset     (reset),
    .word      (word),
    .armed_next(armed_next)
  );

  // Assemble the word and the pre-register output; inversion uses this edge's flag.
  always_comb begin
    word = {N0, N1, N2, N3, N4};
    z_d  = core_func(word) ^ armed_next;
  end

  // Output register.
  always_ff @(posedge CK) begin
    if (reset) begin
      z_q <= 1'b0;
    end else begin
      z_q <= z_d;
    end
  end

  assign Z = z_q;

endmodule

// File: tb/tb_i12287_bench_core.sv
// Self-checking bench: directed vector table, exhaustive sweep, randomized run.
module tb_i12287_bench_core;

  localparam int unsigned TRIG = 4;

  typedef struct {
    logic       rst;
    logic [4:0] w;
    logic       z;
  } vec_t;

  logic       ck;
  logic       rst;
  logic [4:0] w;
  logic       z;

  int vectors;
  int miscompares;

  // Reference model state: length of the current all-ones run, sticky flag.
  int run_len;
  bit armed_m;

  vec_t tbl[$];

  i12287_bench_core #(
    .TRIG_COUNT(TRIG),
    .CNT_W     (4)
  ) dut (
    .CK   (ck),
    .reset(rst),
    .N0   (w[4]),
    .N1   (w[3]),
    .N2   (w[2]),
    .N3   (w[1]),
    .N4   (w[0]),
    .Z    (z)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  function automatic logic f_ref(input logic [4:0] v);
    logic a, b, c;
    a = v[4] && v[3];
    b = v[2] || v[1];
    c = v[0];
    return a ^ b ^ c;
  endfunction

  // Advance the model by one edge and return the expected Z after it.
  task automatic model_step(input logic r, input logic [4:0] v, output logic exp_z);
    if (r) begin
      run_len = 0;
      armed_m = 1'b0;
      exp_z   = 1'b0;
    end else begin
      run_len = (v == 5'd31) ? run_len + 1 : 0;
      if (run_len >= TRIG) armed_m = 1'b1;
      exp_z = f_ref(v) ^ armed_m;
    end
  endtask

  task automatic check(input string name, input logic exp_z);
    vectors++;
    if (z !== exp_z) begin
      miscompares++;
      $display("FAIL %s: rst=%0b w=%05b Z=%b expected %b (t=%0t)", name, rst, w, z, exp_z,
               $time);
    end
  endtask

  // Drive one word away from the edge, clock it, and sample just after the edge.
  task automatic apply(input logic r, input logic [4:0] v);
    @(negedge ck);
    rst = r;
    w   = v;
    @(posedge ck);
    #1;
  endtask

  task automatic step_model(input string name, input logic r, input logic [4:0] v);
    logic e;
    apply(r, v);
    model_step(r, v, e);
    check(name, e);
  endtask

  task automatic add(input logic r, input logic [4:0] v, input logic e);
    vec_t t;
    t.rst = r;
    t.w   = v;
    t.z   = e;
    tbl.push_back(t);
  endtask

  initial begin
    logic dummy;
    vectors     = 0;
    miscompares = 0;
    run_len     = 0;
    armed_m     = 1'b0;
    rst         = 1'b1;
    w           = 5'b0;

    // Reset and idle.
    add(1, 5'b00000, 0);
    add(0, 5'b00000, 0);
    // Truth-table sample points; F(11111) = 1 ^ 1 ^ 1 = 1.
    add(0, 5'b00001, 1);
    add(0, 5'b00100, 1);
    add(0, 5'b11000, 1);
    add(0, 5'b11010, 0);
    add(0, 5'b11111, 1);
    add(0, 5'b00000, 0);
    // Arm on the 4th consecutive all-ones edge, then the inversion persists.
    add(0, 5'b11111, 1);
    add(0, 5'b11111, 1);
    add(0, 5'b11111, 1);
    add(0, 5'b11111, 0);
    add(0, 5'b00000, 1);
    add(0, 5'b00001, 0);
    add(0, 5'b11010, 1);
    // Reset while armed (with an all-ones word): reset wins.
    add(1, 5'b11111, 0);
    add(0, 5'b00001, 1);
    // Broken run never arms.
    add(0, 5'b11111, 1);
    add(0, 5'b11111, 1);
    add(0, 5'b11111, 1);
    add(0, 5'b00000, 0);
    add(0, 5'b11111, 1);
    add(0, 5'b11111, 1);
    add(0, 5'b11111, 1);
    add(0, 5'b00110, 1);
    // Reset mid-run clears the count: three more ones after it must not arm.
    add(0, 5'b11111, 1);
    add(0, 5'b11111, 1);
    add(1, 5'b11111, 0);
    add(0, 5'b11111, 1);
    add(0, 5'b11111, 1);
    add(0, 5'b11111, 1);
    add(0, 5'b11111, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].rst, tbl[i].w);
      model_step(tbl[i].rst, tbl[i].w, dummy);
      check($sformatf("table[%0d]", i), tbl[i].z);
    end

    // Saturation: 20 consecutive all-ones words; armed from the 4th edge on.
    apply(1, 5'b00000);
    model_step(1, 5'b00000, dummy);
    check("sat_reset", 1'b0);
    for (int i = 1; i <= 20; i++) begin
      apply(0, 5'b11111);
      model_step(0, 5'b11111, dummy);
      check($sformatf("sat[%0d]", i), (i < TRIG) ? 1'b1 : 1'b0);
    end
    apply(0, 5'b00001);
    model_step(0, 5'b00001, dummy);
    check("sat_after", 1'b0);

    // Exhaustive sweep after reset: Z tracks F one cycle late.
    step_model("sweep_reset", 1, 5'b00000);
    for (int v = 0; v < 32; v++) begin
      step_model($sformatf("sweep[%05b]", v[4:0]), 0, v[4:0]);
    end

    // Randomized: heavy all-ones bias so runs reach the threshold; occasional reset.
    for (int i = 0; i < 2000; i++) begin
      logic       r;
      logic [4:0] v;
      r = ($urandom_range(0, 39) == 0);
      v = ($urandom_range(0, 1) == 0) ? 5'b11111 : 5'($urandom_range(0, 31));
      step_model($sformatf("rand[%0d]", i), r, v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
